// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and data access, with anti-starvation for fetch.
// Optional watchdog timeout enabled by defining MEM_ARB_WATCHDOG_EN.
module mem_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic [63:0] d_rdata,
  output logic        d_valid,
  output logic        d_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, IF_BUSY, D_BUSY} state_e;
  state_e      state_q;
  logic [3:0]  starve_q;
  logic        mem_req_q, mem_we_q, if_valid_q, d_valid_q;
  logic [63:0] mem_addr_q, mem_wdata_q, d_rdata_q;
  logic [31:0] if_rdata_q;
  logic        force_if, timeout, done;
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_cfg
    $error("mem_arbiter: parameter out of range");
  end
  assign force_if = if_req && starve_q == 4'(STARVE_LIMIT);
  assign done     = state_q != IDLE && (mem_ack || timeout);
`ifdef MEM_ARB_WATCHDOG_EN
  logic [7:0] wdog_q;
  logic       err_q;
  assign timeout = state_q != IDLE && !mem_ack && wdog_q == 8'(TIMEOUT_CYCLES - 1);
  assign err     = err_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q <= '0;
      err_q  <= 1'b0;
    end else begin
      wdog_q <= (state_q == IDLE || done) ? 8'd0 : wdog_q + 8'd1;
      err_q  <= err_q | timeout;
    end
  end
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif
  // Stalls are gated by reset so every output reads zero while reset is held.
  assign if_stall  = reset && if_req && !if_valid_q;
  assign d_stall   = reset && d_req && !d_valid_q;
  assign if_valid  = if_valid_q;
  assign d_valid   = d_valid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      d_valid_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      if_valid_q <= 1'b0;
      d_valid_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (d_req && !force_if) begin
            state_q     <= D_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= d_we;
            mem_addr_q  <= d_addr;
            mem_wdata_q <= d_wdata;
            if (if_req && starve_q != 4'(STARVE_LIMIT)) starve_q <= starve_q + 4'd1;
          end else if (if_req) begin
            state_q     <= IF_BUSY;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr;
            mem_wdata_q <= '0;
            starve_q    <= '0;
          end
        end
        IF_BUSY: begin
          if (done) begin
            state_q    <= IDLE;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            if_valid_q <= 1'b1;
            if_rdata_q <= mem_ack ? mem_rdata[31:0] : 32'd0;
          end
        end
        D_BUSY: begin
          if (done) begin
            state_q   <= IDLE;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            d_valid_q <= 1'b1;
            d_rdata_q <= (mem_ack && !mem_we_q) ? mem_rdata : 64'd0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a memory responder model.
module tb_mem_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [63:0] if_addr = '0, d_addr = '0, d_wdata = '0;
  logic [31:0] if_rdata;
  logic        if_valid, if_stall, d_valid, d_stall;
  logic [63:0] d_rdata;
  logic        mem_req, mem_we, err;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ack = 1'b0;
  logic [63:0] mem_rdata = '0;

  mem_arbiter dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [63:0] addr; logic we; logic [63:0] wdata; } req_t;
  typedef struct { logic is_d; logic [63:0] data; } rsp_t;
  req_t req_q[$];
  rsp_t rsp_q[$];
  req_t exp_req;
  rsp_t exp_rsp;
  int vectors = 0, miscompares = 0;
  int ack_dly = 0, busy_cnt = 0;
  bit spur_ack = 1'b0;
  logic [63:0] first_addr = '0;

  function automatic logic [63:0] rdata_fn(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_0000, a[31:0] ^ 32'h0050_00D3};
  endfunction

  function automatic logic [63:0] fetch_word(input logic [63:0] a);
    logic [63:0] w;
    w = rdata_fn(a);
    return {32'd0, w[31:0]};
  endfunction

  // Memory responder plus scoreboard: grants and completions are checked against queued expectations.
  always @(negedge clk) begin
    if (mem_req) begin
      busy_cnt++;
      if (busy_cnt == 1) begin
        first_addr = mem_addr;
        vectors++;
        if (req_q.size() == 0) begin
          miscompares++;
          $display("FAIL grant: unexpected mem request addr=%h, none expected", mem_addr);
        end else begin
          exp_req = req_q.pop_front();
          if ({mem_addr, mem_we, mem_wdata} !== {exp_req.addr, exp_req.we, exp_req.wdata}) begin
            miscompares++;
            $display("FAIL grant: got addr=%h we=%b wdata=%h, want addr=%h we=%b wdata=%h",
                     mem_addr, mem_we, mem_wdata, exp_req.addr, exp_req.we, exp_req.wdata);
          end
        end
      end else if (mem_addr !== first_addr) begin
        vectors++;
        miscompares++;
        $display("FAIL addr_hold: got %h, want %h", mem_addr, first_addr);
      end
      mem_ack   = busy_cnt > ack_dly;
      mem_rdata = mem_ack ? rdata_fn(mem_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end else begin
      busy_cnt  = 0;
      mem_ack   = spur_ack;
      mem_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
    end
    if (if_valid || d_valid) begin
      vectors++;
      if (rsp_q.size() == 0) begin
        miscompares++;
        $display("FAIL response: unexpected valid if=%b d=%b, none expected", if_valid, d_valid);
      end else begin
        exp_rsp = rsp_q.pop_front();
        if (exp_rsp.is_d !== d_valid || if_valid === d_valid ||
            (d_valid ? d_rdata : {32'd0, if_rdata}) !== exp_rsp.data) begin
          miscompares++;
          $display("FAIL response: got if=%b d=%b if_rdata=%h d_rdata=%h, want is_d=%b data=%h",
                   if_valid, d_valid, if_rdata, d_rdata, exp_rsp.is_d, exp_rsp.data);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [63:0] a, input logic we, input logic [63:0] wd,
                      input logic is_d, input logic [63:0] rd);
    req_q.push_back('{a, we, wd});
    rsp_q.push_back('{is_d, rd});
  endtask

  task automatic wait_valid(input bit is_d, input int limit, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!(is_d ? d_valid : if_valid) && cycles < limit);
    vectors++;
    if (!(is_d ? d_valid : if_valid)) begin
      miscompares++;
      $display("FAIL %s_wait: no valid after %0d cycles, want one", is_d ? "d" : "if", limit);
    end
  endtask

  task automatic test_reset();
    if_req = 1'b1;
    d_req  = 1'b1;
    repeat (2) tick();
    vectors++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, if_valid, d_valid, if_rdata, d_rdata, if_stall, d_stall, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got req=%b stalls=%b%b err=%b, want all 0", mem_req, if_stall, d_stall, err);
    end
    if_req = 1'b0;
    d_req  = 1'b0;
    reset  = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b0 || if_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got mem_req=%b if_stall=%b, want 0 0", mem_req, if_stall);
    end
  endtask

  task automatic test_fetch();
    ack_dly = 0;
    push(64'h40, 1'b0, 64'h0, 1'b0, 64'h0050_0093);
    if_addr = 64'h40;
    if_req  = 1'b1;
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h40 || mem_we !== 1'b0 || if_stall !== 1'b1 || if_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_issue: got req=%b addr=%h we=%b stall=%b valid=%b, want 1 40 0 1 0",
               mem_req, mem_addr, mem_we, if_stall, if_valid);
    end
    tick();
    vectors++;
    if (if_valid !== 1'b1 || if_rdata !== 32'h0050_0093 || if_stall !== 1'b0) begin
      miscompares++;
      $display("FAIL fetch_latency: got valid=%b rdata=%h stall=%b, want 1 00500093 0", if_valid, if_rdata, if_stall);
    end
    if_req = 1'b0;
    tick();
    vectors++;
    if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0050_0093) begin
      miscompares++;
      $display("FAIL fetch_hold: got valid=%b req=%b rdata=%h, want 0 0 00500093", if_valid, mem_req, if_rdata);
    end
  endtask

  task automatic test_priority();
    int c;
    ack_dly = 1;
    push(64'h100, 1'b1, 64'hDEAD, 1'b1, 64'h0);
    push(64'h200, 1'b0, 64'h0, 1'b0, fetch_word(64'h200));
    if_addr = 64'h200;
    if_req  = 1'b1;
    d_addr  = 64'h100;
    d_we    = 1'b1;
    d_wdata = 64'hDEAD;
    d_req   = 1'b1;
    tick();
    vectors++;
    if (mem_we !== 1'b1 || mem_wdata !== 64'hDEAD || d_stall !== 1'b1 || if_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL prio_data_first: got we=%b wdata=%h stalls=%b%b, want 1 dead 11", mem_we, mem_wdata, if_stall, d_stall);
    end
    wait_valid(1'b1, 10, c);
    d_req = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || if_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL turnaround: got mem_req=%b if_stall=%b, want 0 1", mem_req, if_stall);
    end
    tick();
    vectors++;
    if (mem_req !== 1'b1 || mem_addr !== 64'h200 || mem_we !== 1'b0) begin
      miscompares++;
      $display("FAIL prio_fetch_next: got req=%b addr=%h we=%b, want 1 200 0", mem_req, mem_addr, mem_we);
    end
    wait_valid(1'b0, 10, c);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_starve();
    int c;
    ack_dly = 0;
    d_we    = 1'b0;
    d_wdata = 64'h0;
    for (int i = 0; i < 4; i++) push(64'h1000 + 64'(8 * i), 1'b0, 64'h0, 1'b1, rdata_fn(64'h1000 + 64'(8 * i)));
    push(64'h300, 1'b0, 64'h0, 1'b0, fetch_word(64'h300));
    push(64'h1020, 1'b0, 64'h0, 1'b1, rdata_fn(64'h1020));
    if_addr = 64'h300;
    if_req  = 1'b1;
    d_addr  = 64'h1000;
    d_req   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_valid(1'b1, 10, c);
      d_addr = 64'h1000 + 64'(8 * (i + 1));
    end
    wait_valid(1'b0, 10, c);
    if_req = 1'b0;
    vectors++;
    if (d_stall !== 1'b1) begin
      miscompares++;
      $display("FAIL starve_data_pending: got d_stall=%b, want 1", d_stall);
    end
    wait_valid(1'b1, 10, c);
    d_req = 1'b0;
    tick();
    // With the counter cleared, data must win a fresh contention again.
    push(64'h2000, 1'b0, 64'h0, 1'b1, rdata_fn(64'h2000));
    push(64'h340, 1'b0, 64'h0, 1'b0, fetch_word(64'h340));
    d_addr  = 64'h2000;
    if_addr = 64'h340;
    d_req   = 1'b1;
    if_req  = 1'b1;
    wait_valid(1'b1, 10, c);
    d_req = 1'b0;
    wait_valid(1'b0, 10, c);
    if_req = 1'b0;
    tick();
  endtask

  task automatic test_inflight();
    int c;
    spur_ack = 1'b1;
    repeat (3) tick();
    spur_ack = 1'b0;
    vectors++;
    if (mem_req !== 1'b0 || if_valid !== 1'b0 || d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL idle_ack: got req=%b valids=%b%b, want 0 00", mem_req, if_valid, d_valid);
    end
    ack_dly = 3;
    push(64'h500, 1'b0, 64'h0, 1'b1, rdata_fn(64'h500));
    d_addr = 64'h500;
    d_we   = 1'b0;
    d_req  = 1'b1;
    tick();
    d_req  = 1'b0;
    d_addr = 64'hFFF;
    wait_valid(1'b1, 10, c);
    vectors++;
    if (c != 4) begin
      miscompares++;
      $display("FAIL inflight_latency: got %0d cycles, want 4", c);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    ack_dly = 1000;
    req_q.push_back('{64'h600, 1'b0, 64'h0});
    d_addr = 64'h600;
    d_req  = 1'b1;
    repeat (2) tick();
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (mem_req !== 1'b0 || d_valid !== 1'b0 || d_stall !== 1'b0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: got req=%b valid=%b stall=%b err=%b, want 0 0 0 0", mem_req, d_valid, d_stall, err);
    end
    d_req = 1'b0;
    tick();
    reset   = 1'b1;
    ack_dly = 0;
    repeat (5) tick();
    vectors++;
    if (mem_req !== 1'b0 || d_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon: got req=%b valid=%b, want 0 0", mem_req, d_valid);
    end
  endtask

  task automatic test_watchdog();
    int c, hi, seen;
    hi   = 0;
    seen = 0;
    ack_dly = 1000;
    d_addr  = 64'h700;
    d_we    = 1'b0;
`ifdef MEM_ARB_WATCHDOG_EN
    push(64'h700, 1'b0, 64'h0, 1'b1, 64'h0);
    d_req = 1'b1;
    for (int i = 0; i < 40 && seen == 0; i++) begin
      tick();
      if (mem_req) hi++;
      if (d_valid) seen = 1;
    end
    d_req = 1'b0;
    vectors++;
    if (hi != 16 || seen != 1 || d_rdata !== 64'h0 || err !== 1'b1) begin
      miscompares++;
      $display("FAIL watchdog: got busy=%0d valid=%0d rdata=%h err=%b, want 16 1 0 1", hi, seen, d_rdata, err);
    end
    ack_dly = 0;
    push(64'h40, 1'b0, 64'h0, 1'b0, fetch_word(64'h40));
    if_addr = 64'h40;
    if_req  = 1'b1;
    wait_valid(1'b0, 10, c);
    if_req = 1'b0;
    tick();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_sticky: got err=%b, want 1", err);
    end
    reset = 1'b0;
    #1;
    vectors++;
    if (err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_reset: got err=%b, want 0", err);
    end
    tick();
    reset = 1'b1;
    tick();
`else
    push(64'h700, 1'b0, 64'h0, 1'b1, rdata_fn(64'h700));
    d_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (d_valid) seen++;
    end
    vectors++;
    if (mem_req !== 1'b1 || seen != 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL no_watchdog: got req=%b valids=%0d err=%b, want 1 0 0", mem_req, seen, err);
    end
    ack_dly = 0;
    wait_valid(1'b1, 5, c);
    d_req = 1'b0;
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_starve();
    test_inflight();
    test_reset_mid();
    test_watchdog();
    vectors++;
    if (req_q.size() != 0 || rsp_q.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain: got %0d grants and %0d responses left, want 0 0", req_q.size(), rsp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
